// File: rtl/ps2_kbd_cfg_ctrl.sv
// PS/2 keyboard bring-up (reset, BAT, LED programming) and runtime LED updates, then scancode forwarding.
// Define PS2_TYPEMATIC_CFG_EN to also program the typematic rate (F3 + TYPEMATIC) during bring-up.
module ps2_kbd_cfg_ctrl #(
    parameter logic [26:0] RESP_TIMEOUT = 27'd2_000_000,
    parameter logic [26:0] BAT_TIMEOUT  = 27'd75_000_000,
`ifdef PS2_TYPEMATIC_CFG_EN
    parameter logic [7:0]  TYPEMATIC    = 8'h20,
`endif
    parameter logic [1:0]  MAX_RETRY    = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_code,
    input  logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic       tx_done,
    input  logic [2:0] led_state,
    input  logic       led_update,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       init_done,
    output logic       cfg_error
);
    localparam int unsigned TIMER_W = 27;

    localparam logic [7:0] BYTE_ACK      = 8'hFA;
    localparam logic [7:0] BYTE_RESEND   = 8'hFE;
    localparam logic [7:0] BYTE_BAT_OK   = 8'hAA;
    localparam logic [7:0] BYTE_BAT_FAIL = 8'hFC;

    typedef enum logic [2:0] {
        S_SEND,
        S_WAIT_TX,
        S_WAIT_ACK,
        S_WAIT_BAT,
        S_READY,
        S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        STEP_RST,
        STEP_LEDCMD,
        STEP_LEDARG
`ifdef PS2_TYPEMATIC_CFG_EN
        , STEP_TYPCMD,
        STEP_TYPARG
`endif
    } step_t;

    state_t               state, state_nxt;
    step_t                step, step_nxt;
    logic [TIMER_W-1:0]   timer;
    logic [1:0]           retry, retry_nxt;
    logic                 led_pending;
    logic [2:0]           led_latch;
    logic [7:0]           cmd_byte;
    logic                 send, fwd, enter_ledcmd, retry_req;
    logic                 resp_expired, bat_expired;
    logic [7:0]           tx_data_nxt, key_code_nxt;
    logic                 tx_start_nxt, key_valid_nxt, init_done_nxt, cfg_error_nxt;
`ifdef PS2_TYPEMATIC_CFG_EN
    logic                 boot;
`endif

    assign resp_expired = (timer >= RESP_TIMEOUT);
    assign bat_expired  = (timer >= BAT_TIMEOUT);

    // Byte transmitted for the current sub-step
    always_comb begin
        cmd_byte = 8'hFF;
        case (step)
            STEP_RST:    cmd_byte = 8'hFF;
            STEP_LEDCMD: cmd_byte = 8'hED;
            STEP_LEDARG: cmd_byte = {5'b00000, led_latch};
`ifdef PS2_TYPEMATIC_CFG_EN
            STEP_TYPCMD: cmd_byte = 8'hF3;
            STEP_TYPARG: cmd_byte = TYPEMATIC;
`endif
            default:     cmd_byte = 8'hFF;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_SEND;
            step  <= STEP_RST;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    // Next-state logic; a resend or timeout reuses the current sub-step
    always_comb begin
        state_nxt    = state;
        step_nxt     = step;
        retry_nxt    = retry;
        send         = 1'b0;
        fwd          = 1'b0;
        enter_ledcmd = 1'b0;
        retry_req    = 1'b0;
        case (state)
            S_SEND: begin
                if (!tx_busy) begin
                    send      = 1'b1;
                    state_nxt = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (tx_done) begin
                    state_nxt = S_WAIT_ACK;
                end else if (resp_expired) begin
                    retry_req = 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (rx_ready && rx_code == BYTE_ACK) begin
                    retry_nxt = 2'd0;
                    case (step)
                        STEP_RST:    state_nxt = S_WAIT_BAT;
                        STEP_LEDCMD: begin
                            state_nxt = S_SEND;
                            step_nxt  = STEP_LEDARG;
                        end
`ifdef PS2_TYPEMATIC_CFG_EN
                        STEP_LEDARG: begin
                            if (boot) begin
                                state_nxt = S_SEND;
                                step_nxt  = STEP_TYPCMD;
                            end else begin
                                state_nxt = S_READY;
                            end
                        end
                        STEP_TYPCMD: begin
                            state_nxt = S_SEND;
                            step_nxt  = STEP_TYPARG;
                        end
                        STEP_TYPARG: state_nxt = S_READY;
`else
                        STEP_LEDARG: state_nxt = S_READY;
`endif
                        default:     state_nxt = S_ERROR;
                    endcase
                end else if (rx_ready && rx_code == BYTE_RESEND) begin
                    retry_req = 1'b1;
                end else if (resp_expired) begin
                    retry_req = 1'b1;
                end
            end
            S_WAIT_BAT: begin
                if (rx_ready && rx_code == BYTE_BAT_OK) begin
                    state_nxt    = S_SEND;
                    step_nxt     = STEP_LEDCMD;
                    enter_ledcmd = 1'b1;
                end else if ((rx_ready && rx_code == BYTE_BAT_FAIL) || bat_expired) begin
                    state_nxt = S_ERROR;
                end
            end
            S_READY: begin
                fwd = rx_ready;
                // Hot-plug BAT or a (possibly deferred) LED request restarts LED programming
                if ((rx_ready && rx_code == BYTE_BAT_OK) || led_update || led_pending) begin
                    state_nxt    = S_SEND;
                    step_nxt     = STEP_LEDCMD;
                    enter_ledcmd = 1'b1;
                end
            end
            S_ERROR:  state_nxt = S_ERROR;
            default:  state_nxt = S_ERROR;
        endcase
        if (retry_req) begin
            if (retry < MAX_RETRY) begin
                retry_nxt = retry + 2'd1;
                state_nxt = S_SEND;
            end else begin
                state_nxt = S_ERROR;
            end
        end
    end

    // Next values of the registered outputs
    always_comb begin
        tx_start_nxt  = send;
        tx_data_nxt   = send ? cmd_byte : tx_data;
        key_valid_nxt = fwd;
        key_code_nxt  = fwd ? rx_code : key_code;
        init_done_nxt = (state_nxt == S_READY);
        cfg_error_nxt = cfg_error || (state_nxt == S_ERROR);
    end

    // Timer, retry count, LED request bookkeeping and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer       <= '0;
            retry       <= 2'd0;
            led_pending <= 1'b1;
            led_latch   <= 3'b000;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            key_code    <= 8'h00;
            key_valid   <= 1'b0;
            init_done   <= 1'b0;
            cfg_error   <= 1'b0;
`ifdef PS2_TYPEMATIC_CFG_EN
            boot        <= 1'b1;
`endif
        end else begin
            if (state_nxt != state) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + TIMER_W'(1);
            end
            retry <= retry_nxt;
            if (enter_ledcmd) begin
                if (led_pending || led_update) begin
                    led_latch <= led_state;
                end
                led_pending <= 1'b0;
            end else if (led_update) begin
                led_pending <= 1'b1;
            end
            tx_data   <= tx_data_nxt;
            tx_start  <= tx_start_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            init_done <= init_done_nxt;
            cfg_error <= cfg_error_nxt;
`ifdef PS2_TYPEMATIC_CFG_EN
            if (state_nxt == S_READY) begin
                boot <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_kbd_cfg_ctrl.sv
// Bench for ps2_kbd_cfg_ctrl: scripted keyboard/transmitter, protocol-level model checked every cycle.
module tb_ps2_kbd_cfg_ctrl;
    logic       clk;
    logic       rst;
    logic [7:0] rx_code;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] led_state;
    logic       led_update;
    logic [7:0] key_code;
    logic       key_valid;
    logic       init_done;
    logic       cfg_error;

    int n_chk  = 0;
    int n_fail = 0;
    int n_seen = 0;

    logic [7:0] tx_log[$];
    logic [7:0] kv_log[$];

    // Model state: what the outputs must be, derived from observed protocol traffic
    bit         m_ready, m_err, m_acked, m_arg, kv_exp, prev_busy, prev_start, nxt_ready;
    logic [7:0] m_last_tx, kc_exp;

    ps2_kbd_cfg_ctrl #(
        .RESP_TIMEOUT(27'd100),
        .BAT_TIMEOUT (27'd2000),
        .MAX_RETRY   (2'd3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_code   (rx_code),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .led_state (led_state),
        .led_update(led_update),
        .key_code  (key_code),
        .key_valid (key_valid),
        .init_done (init_done),
        .cfg_error (cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transmitter model: busy for 4 cycles after tx_start, then a one-cycle tx_done
    initial begin
        int cnt;
        cnt     = 0;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (rst) begin
                cnt     = 0;
                tx_busy = 1'b0;
            end else if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    tx_busy = 1'b0;
                    tx_done = 1'b1;
                end
            end else if (tx_start) begin
                tx_log.push_back(tx_data);
                cnt     = 4;
                tx_busy = 1'b1;
            end
        end
    end

    // Compare process: outputs against the model every cycle
    always @(negedge clk) begin
        if (rst) begin
            m_ready = 0; m_err = 0; m_acked = 1; m_arg = 0; m_last_tx = 8'h00;
            kv_exp = 0; kc_exp = 8'h00; prev_busy = 0; prev_start = 0;
            check(tx_data == 8'h00 && !tx_start && key_code == 8'h00 && !key_valid && !init_done && !cfg_error,
                  "reset_outputs", {12'h0, tx_data, 3'b0, tx_start, key_code, key_valid, init_done, cfg_error}, 32'h0);
        end else begin
            check(init_done == m_ready, "init_done", 32'(init_done), 32'(m_ready));
            check(key_valid == kv_exp, "key_valid", 32'(key_valid), 32'(kv_exp));
            if (kv_exp) check(key_code == kc_exp, "key_code", 32'(key_code), 32'(kc_exp));
            if (key_valid) kv_log.push_back(key_code);
            if (m_err) check(cfg_error == 1'b1, "cfg_error", 32'(cfg_error), 32'd1);
            if (tx_start) begin
                check(!prev_busy && !prev_start && !cfg_error && !m_ready, "tx_start_legal",
                      {28'h0, prev_busy, prev_start, cfg_error, m_ready}, 32'h0);
                m_arg     = (m_last_tx == 8'hED && m_acked) || (m_arg && !m_acked && tx_data == m_last_tx);
                m_last_tx = tx_data;
                m_acked   = 0;
            end
            kv_exp    = rx_ready && m_ready;
            kc_exp    = rx_code;
            nxt_ready = m_ready;
            if (m_ready && ((rx_ready && rx_code == 8'hAA) || led_update)) nxt_ready = 0;
            if (rx_ready && !m_ready && !m_acked && rx_code == 8'hFA) begin
                m_acked = 1;
                if (m_arg) nxt_ready = 1;
            end else if (rx_ready && !m_ready && m_acked && m_last_tx == 8'hFF && rx_code == 8'hFC) begin
                m_err = 1;
            end
            m_ready    = nxt_ready;
            prev_busy  = tx_busy;
            prev_start = tx_start;
        end
    end

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        rx_code  = b;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic wait_new_tx(output bit got);
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            got = tx_log.size() > n_seen;
        end
        if (!got) check(1'b0, "tx_wait_timeout", 32'(tx_log.size()), 32'(n_seen + 1));
    endtask

    task automatic expect_tx(input logic [7:0] b, input string nm);
        bit got;
        wait_new_tx(got);
        if (got) begin
            check(tx_log[n_seen] == b, nm, 32'(tx_log[n_seen]), 32'(b));
            n_seen++;
            for (int i = 0; i < 50 && tx_busy; i++) @(negedge clk);
        end
    endtask

    task automatic xfer(input logic [7:0] b, input logic [7:0] resp, input string nm);
        expect_tx(b, nm);
        send_rx(resp);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b1; rx_ready = 1'b0; led_update = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        n_seen = tx_log.size();
    endtask

    initial begin
        int base, kbase;
        bit got;
        rst = 1'b1; rx_code = 8'h00; rx_ready = 1'b0; led_state = 3'b010; led_update = 1'b0;
        repeat (3) @(negedge clk);
        check(tx_data == 8'h00, "rst_tx_data", 32'(tx_data), 32'h00);
        check(tx_start == 1'b0, "rst_tx_start", 32'(tx_start), 32'h0);
        check(key_valid == 1'b0 && key_code == 8'h00, "rst_key", {23'h0, key_valid, key_code}, 32'h0);
        check(init_done == 1'b0 && cfg_error == 1'b0, "rst_flags", {30'h0, init_done, cfg_error}, 32'h0);
        #2 rst = 1'b0;

        // Nominal bring-up with a stray byte during the BAT wait
        base = tx_log.size();
        xfer(8'hFF, 8'hFA, "boot_ff");
        send_rx(8'h1C);
        send_rx(8'hAA);
        xfer(8'hED, 8'hFA, "boot_ed");
        xfer(8'h02, 8'hFA, "boot_arg");
        repeat (3) @(negedge clk);
        check(init_done == 1'b1, "boot_init_done", 32'(init_done), 32'd1);
        check(tx_log.size() - base == 3, "boot_tx_count", 32'(tx_log.size() - base), 32'd3);
        check(kv_log.size() == 0, "no_key_before_ready", 32'(kv_log.size()), 32'd0);

        // Forwarding
        kbase = kv_log.size();
        send_rx(8'h1C); send_rx(8'hF0); send_rx(8'h1C);
        repeat (2) @(negedge clk);
        check(kv_log.size() - kbase == 3, "fwd_count", 32'(kv_log.size() - kbase), 32'd3);
        if (kv_log.size() - kbase == 3) begin
            check(kv_log[kbase] == 8'h1C, "fwd_0", 32'(kv_log[kbase]), 32'h1C);
            check(kv_log[kbase+1] == 8'hF0, "fwd_1", 32'(kv_log[kbase+1]), 32'hF0);
            check(kv_log[kbase+2] == 8'h1C, "fwd_2", 32'(kv_log[kbase+2]), 32'h1C);
        end

        // LED update on the same cycle as a scancode
        led_state = 3'b101;
        @(posedge clk); #1;
        rx_code = 8'h79; rx_ready = 1'b1; led_update = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0; led_update = 1'b0;
        xfer(8'hED, 8'hFA, "led_ed");
        xfer(8'h05, 8'hFA, "led_arg");
        repeat (3) @(negedge clk);
        check(kv_log.size() > 0 && kv_log[$] == 8'h79, "collision_key", 32'(kv_log[$]), 32'h79);
        check(init_done == 1'b1, "led_ready", 32'(init_done), 32'd1);

        // Hot-plug BAT: no pending request, so the latched LED value is reused
        led_state = 3'b111;
        send_rx(8'hAA);
        xfer(8'hED, 8'hFA, "hotplug_ed");
        xfer(8'h05, 8'hFA, "hotplug_arg");
        repeat (3) @(negedge clk);
        check(kv_log[$] == 8'hAA, "hotplug_fwd", 32'(kv_log[$]), 32'hAA);
        check(init_done == 1'b1, "hotplug_ready", 32'(init_done), 32'd1);

        // BAT failure
        do_reset();
        xfer(8'hFF, 8'hFA, "batfail_ff");
        send_rx(8'hFC);
        repeat (3) @(negedge clk);
        check(cfg_error == 1'b1 && init_done == 1'b0, "batfail_flags", {30'h0, cfg_error, init_done}, 32'h2);
        base = tx_log.size();
        repeat (100) @(negedge clk);
        check(tx_log.size() == base, "batfail_no_tx", 32'(tx_log.size()), 32'(base));

        // Reset while waiting for tx_done, then resend handling
        do_reset();
        led_state = 3'b010;
        wait_new_tx(got);
        if (got) begin
            check(tx_log[n_seen] == 8'hFF, "midrst_ff", 32'(tx_log[n_seen]), 32'hFF);
            #2 rst = 1'b1;
            #1;
            check(tx_start == 1'b0 && tx_data == 8'h00, "midrst_async", {23'h0, tx_start, tx_data}, 32'h0);
            repeat (2) @(negedge clk);
            #2 rst = 1'b0;
            n_seen = tx_log.size();
        end
        base = tx_log.size();
        xfer(8'hFF, 8'hFE, "resend_ff0");
        xfer(8'hFF, 8'hFA, "resend_ff1");
        send_rx(8'hAA);
        for (int i = 0; i < 3; i++) xfer(8'hED, 8'hFE, "resend_ed");
        xfer(8'hED, 8'hFA, "resend_ed_last");
        xfer(8'h02, 8'hFA, "resend_arg");
        repeat (3) @(negedge clk);
        check(init_done == 1'b1 && cfg_error == 1'b0, "resend_ready", {30'h0, init_done, cfg_error}, 32'h2);
        check(tx_log.size() - base == 7, "resend_tx_count", 32'(tx_log.size() - base), 32'd7);

        // Timeout exhaustion on ED
        do_reset();
        xfer(8'hFF, 8'hFA, "to_ff");
        send_rx(8'hAA);
        for (int i = 0; i < 4; i++) expect_tx(8'hED, "to_ed");
        got = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            got = cfg_error;
        end
        check(got == 1'b1 && init_done == 1'b0, "to_error", {30'h0, got, init_done}, 32'h2);
        base = tx_log.size();
        repeat (400) @(negedge clk);
        check(tx_log.size() == base, "to_no_tx", 32'(tx_log.size()), 32'(base));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
